// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - shared FSM encoding, default widths and direction codes for the stepper path
package step_pkg;

  localparam int DELTA_W_DEF  = 16;
  localparam int PERIOD_W_DEF = 24;

  // Direction code seen by the phase driver: 0 walks the phase table forward, 1 in reverse
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/step_tick_gen.sv
// rtl/step_tick_gen.sv - reloadable down-counter that fires one tick every (reload_val+1) enabled cycles
module step_tick_gen #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                load,
  input  logic [PERIOD_W-1:0] reload_val,
  input  logic                en,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == '0);

  // Clear beats load beats count; a tick reloads so ticks repeat at a fixed spacing
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load || tick) begin
      cnt_d = reload_val;
    end else if (en) begin
      cnt_d = cnt_q - PERIOD_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/step_line_planner.sv
// rtl/step_line_planner.sv - Bresenham XY move planner; STEP_LINE_POS_EN adds pos_x/pos_y position counters
module step_line_planner
  import step_pkg::*;
#(
  parameter int DELTA_W  = DELTA_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [DELTA_W-1:0]  cmd_dx,
  input  logic [DELTA_W-1:0]  cmd_dy,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                en_x,
  output logic                en_y,
  output logic                dir_x,
  output logic                dir_y,
  output logic                step_x,
  output logic                step_y
`ifdef STEP_LINE_POS_EN
  ,
  output logic [31:0]         pos_x,
  output logic [31:0]         pos_y
`endif
);

  state_e state_q, state_d;

  logic                sign_x_q, sign_x_d, sign_y_q, sign_y_d;
  logic [DELTA_W-1:0]  abs_x_q, abs_x_d, abs_y_q, abs_y_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic signed [DELTA_W:0] err_q, err_d;
  logic [DELTA_W-1:0]  rem_q, rem_d;
  logic                step_x_q, step_x_d, step_y_q, step_y_d;

  logic                major_is_x;
  logic [DELTA_W-1:0]  major, minor;
  logic [DELTA_W-1:0]  dx_abs, dy_abs;
  logic signed [DELTA_W:0] err_t;
  logic                minor_step;
  logic                accept;
  logic                tick, tick_ok;

  // Two's-complement negate keeps the most negative delta as its exact magnitude
  assign dx_abs = cmd_dx[DELTA_W-1] ? (~cmd_dx + DELTA_W'(1)) : cmd_dx;
  assign dy_abs = cmd_dy[DELTA_W-1] ? (~cmd_dy + DELTA_W'(1)) : cmd_dy;

  // X wins ties so equal-length diagonals always step X as the major axis
  assign major_is_x = (abs_x_q >= abs_y_q);
  assign major      = major_is_x ? abs_x_q : abs_y_q;
  assign minor      = major_is_x ? abs_y_q : abs_x_q;

  assign accept  = (state_q == ST_IDLE) && cmd_valid && !abort;
  assign tick_ok = tick && !abort;

  step_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .clear      (abort),
    .load       (state_q == ST_LOAD),
    .reload_val (period_q - PERIOD_W'(1)),
    .en         ((state_q == ST_RUN) && (rem_q != '0)),
    .tick       (tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; RUN lingers one cycle after the last tick so its registered step pulse stays inside RUN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_LOAD;
      ST_LOAD: begin
        if (abort)            state_d = ST_IDLE;
        else if (major == '0) state_d = ST_DONE;
        else                  state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)             state_d = ST_IDLE;
        else if (rem_q == '0)  state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; an abort in DONE withholds the done pulse
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
    done      = (state_q == ST_DONE) && !abort;
    en_x      = busy && (abs_x_q != '0);
    en_y      = busy && (abs_y_q != '0);
    dir_x     = (state_q != ST_IDLE) ? sign_x_q : DIR_POS;
    dir_y     = (state_q != ST_IDLE) ? sign_y_q : DIR_POS;
    step_x    = step_x_q;
    step_y    = step_y_q;
  end

  // Command latch, Bresenham error update and step pulse generation
  always_comb begin
    sign_x_d   = sign_x_q;
    sign_y_d   = sign_y_q;
    abs_x_d    = abs_x_q;
    abs_y_d    = abs_y_q;
    period_d   = period_q;
    err_d      = err_q;
    rem_d      = rem_q;
    step_x_d   = 1'b0;
    step_y_d   = 1'b0;
    minor_step = 1'b0;
    err_t      = err_q - $signed({1'b0, minor});
    if (accept) begin
      sign_x_d = cmd_dx[DELTA_W-1];
      sign_y_d = cmd_dy[DELTA_W-1];
      abs_x_d  = dx_abs;
      abs_y_d  = dy_abs;
      period_d = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
    end
    if (state_q == ST_LOAD) begin
      err_d = $signed({1'b0, major >> 1});
      rem_d = major;
    end
    if (tick_ok) begin
      if (err_t < 0) begin
        err_d      = err_t + $signed({1'b0, major});
        minor_step = 1'b1;
      end else begin
        err_d = err_t;
      end
      rem_d    = rem_q - DELTA_W'(1);
      step_x_d = major_is_x || minor_step;
      step_y_d = !major_is_x || minor_step;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_x_q <= 1'b0;
      sign_y_q <= 1'b0;
      abs_x_q  <= '0;
      abs_y_q  <= '0;
      period_q <= PERIOD_W'(1);
      err_q    <= '0;
      rem_q    <= '0;
      step_x_q <= 1'b0;
      step_y_q <= 1'b0;
    end else begin
      sign_x_q <= sign_x_d;
      sign_y_q <= sign_y_d;
      abs_x_q  <= abs_x_d;
      abs_y_q  <= abs_y_d;
      period_q <= period_d;
      err_q    <= err_d;
      rem_q    <= rem_d;
      step_x_q <= step_x_d;
      step_y_q <= step_y_d;
    end
  end

`ifdef STEP_LINE_POS_EN
  logic [31:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;

  // Position moves at the same edge that raises the step pulse, so it changes with the pulse
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    if (step_x_d) pos_x_d = sign_x_q ? (pos_x_q - 32'd1) : (pos_x_q + 32'd1);
    if (step_y_d) pos_y_d = sign_y_q ? (pos_y_q - 32'd1) : (pos_y_q + 32'd1);
  end

  // Position registers survive moves and aborts
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
`endif

endmodule

// File: tb/tb_step_line_planner.sv
// tb/tb_step_line_planner.sv - directed self-checking bench for step_line_planner
module tb_step_line_planner;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_dx, cmd_dy;
  logic [23:0] cmd_period;
  logic        abort;
  logic        busy, done, en_x, en_y, dir_x, dir_y, step_x, step_y;
`ifdef STEP_LINE_POS_EN
  logic [31:0] pos_x, pos_y;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cnt_x, cnt_y, done_at, en_bad, dir_bad, out_bad;

  always #5 clk = ~clk;

  step_line_planner dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dx     (cmd_dx),
    .cmd_dy     (cmd_dy),
    .cmd_period (cmd_period),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .en_x       (en_x),
    .en_y       (en_y),
    .dir_x      (dir_x),
    .dir_y      (dir_y),
    .step_x     (step_x),
    .step_y     (step_y)
`ifdef STEP_LINE_POS_EN
    ,
    .pos_x      (pos_x),
    .pos_y      (pos_y)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".cmd_ready"}, cmd_ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".en"}, {en_x, en_y}, 0);
    chk({tag, ".dir"}, {dir_x, dir_y}, 0);
    chk({tag, ".step"}, {step_x, step_y}, 0);
  endtask

  // Issue one command from IDLE and watch it until done or the cycle budget runs out
  task automatic run_move(input logic [15:0] dx, input logic [15:0] dy, input logic [23:0] per,
                          input int limit);
    cmd_dx = dx; cmd_dy = dy; cmd_period = per; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cnt_x = 0; cnt_y = 0; done_at = -1; en_bad = 0; dir_bad = 0; out_bad = 0;
    for (int n = 0; n < limit && done_at < 0; n++) begin
      cnt_x += int'(step_x);
      cnt_y += int'(step_y);
      if (busy && ((en_x !== (dx != 0)) || (en_y !== (dy != 0)))) en_bad++;
      if (busy && ((dir_x !== dx[15]) || (dir_y !== dy[15]))) dir_bad++;
      if ((step_x || step_y) && !busy) out_bad++;
      if (done) done_at = n;
      else      cyc();
    end
  endtask

  initial begin
    int cx, cy, dn;
    rst = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
    cmd_dx = '0; cmd_dy = '0; cmd_period = '0;
    cyc(); cyc();
    chk_idle_outputs("reset");
`ifdef STEP_LINE_POS_EN
    chk("reset.pos_x", pos_x, 0);
    chk("reset.pos_y", pos_y, 0);
`endif
    rst = 1'b0;
    cyc();

    // Move (4,2) period 3: steps land at cycles 4,7,10,13 after acceptance, done at 14
    cmd_dx = 16'd4; cmd_dy = 16'd2; cmd_period = 24'd3; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    chk("t1.load.busy", busy, 1);
    chk("t1.load.cmd_ready", cmd_ready, 0);
    chk("t1.load.en", {en_x, en_y}, 2'b11);
    chk("t1.load.dir", {dir_x, dir_y}, 2'b00);
    for (int n = 0; n <= 14; n++) begin
      chk($sformatf("t1.step_x@%0d", n), step_x, (n == 4 || n == 7 || n == 10 || n == 13));
      chk($sformatf("t1.step_y@%0d", n), step_y, (n == 7 || n == 13));
      chk($sformatf("t1.done@%0d", n), done, (n == 14));
      if (n < 14) cyc();
    end
    chk("t1.done.busy", busy, 0);
    cyc();
    chk("t1.after.cmd_ready", cmd_ready, 1);

    // Move (-3,5) with period 0 behaves as period 1, Y major
    run_move(16'hFFFD, 16'd5, 24'd0, 100);
    chk("t2.step_x_count", cnt_x, 3);
    chk("t2.step_y_count", cnt_y, 5);
    chk("t2.done_at", done_at, 7);
    chk("t2.en_bad", en_bad, 0);
    chk("t2.dir_bad", dir_bad, 0);
    chk("t2.out_bad", out_bad, 0);
    cyc();

    // Zero move: LOAD straight to DONE
    run_move(16'd0, 16'd0, 24'd5, 20);
    chk("t3.step_count", cnt_x + cnt_y, 0);
    chk("t3.done_at", done_at, 1);
    chk("t3.en_bad", en_bad, 0);
    cyc();

    // Abort in IDLE drops a same-cycle command
    cmd_dx = 16'd3; cmd_dy = 16'd3; cmd_period = 24'd1; cmd_valid = 1'b1; abort = 1'b1;
    cyc();
    cmd_valid = 1'b0; abort = 1'b0;
    chk("t_idle_abort.busy", busy, 0);
    chk("t_idle_abort.cmd_ready", cmd_ready, 1);

    // Move (10,0) period 2, aborted in the cycle of the 4th tick
    cmd_dx = 16'd10; cmd_dy = 16'd0; cmd_period = 24'd2; cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cx = 0; dn = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      cx += int'(step_x);
      dn += int'(done);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cx += int'(step_x);
    dn += int'(done);
    chk("t4.step_x_count", cx, 3);
    chk("t4.done_count", dn, 0);
    chk_idle_outputs("t4.after_abort");
    run_move(16'd1, 16'd1, 24'd1, 20);
    chk("t4.next.step_x", cnt_x, 1);
    chk("t4.next.step_y", cnt_y, 1);
    chk("t4.next.done_at", done_at, 3);
    cyc();

    // cmd_valid held with changing data: second command waits for IDLE
    cmd_dx = 16'd2; cmd_dy = 16'd1; cmd_period = 24'd1; cmd_valid = 1'b1;
    cyc();
    cmd_dx = 16'd0; cmd_dy = 16'hFFFD; cmd_period = 24'd1;
    cx = 0; cy = 0; dn = -1;
    for (int n = 1; n <= 5; n++) begin
      cyc();
      cx += int'(step_x);
      cy += int'(step_y);
      if (done) dn = n;
    end
    chk("t5.first.step_x", cx, 2);
    chk("t5.first.step_y", cy, 1);
    chk("t5.first.done_at", dn, 4);
    chk("t5.idle.cmd_ready", cmd_ready, 1);
    cyc();
    cmd_valid = 1'b0;
    chk("t5.second.busy", busy, 1);
    chk("t5.second.en", {en_x, en_y}, 2'b01);
    chk("t5.second.dir", {dir_x, dir_y}, 2'b01);
    cyc(); cyc();
    chk("t5.second.step_y", step_y, 1);
    rst = 1'b1;
    cyc();
    chk_idle_outputs("t5.mid_reset");
    rst = 1'b0;
`ifdef STEP_LINE_POS_EN
    chk("t5.reset.pos_x", pos_x, 0);
    chk("t5.reset.pos_y", pos_y, 0);
`endif
    cyc();

`ifdef STEP_LINE_POS_EN
    run_move(16'd5, 16'hFFFE, 24'd1, 50);
    cyc();
    chk("t6.pos_x_a", pos_x, 5);
    chk("t6.pos_y_a", pos_y, 32'hFFFF_FFFE);
    run_move(16'hFFFB, 16'd2, 24'd1, 50);
    cyc();
    chk("t6.pos_x_b", pos_x, 0);
    chk("t6.pos_y_b", pos_y, 0);
`endif

    // Most negative delta: magnitude 32768 must be stepped in full
    run_move(16'h8000, 16'd0, 24'd0, 40000);
    chk("t7.step_x_count", cnt_x, 32768);
    chk("t7.step_y_count", cnt_y, 0);
    chk("t7.done_at", done_at, 32770);
    chk("t7.dir_bad", dir_bad, 0);
    cyc();
`ifdef STEP_LINE_POS_EN
    chk("t7.pos_x", pos_x, 32'hFFFF_8000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
